// File: rtl/lif_neuron_array.sv
// Multi-channel leaky integrate-and-fire neurons: saturating weighted integration,
// periodic leak, threshold/spike, refractory hold. Optional per-channel spike counters via LIF_SPIKE_COUNT_EN.

module lif_neuron_lane #(
  parameter int WIDTH = 8,
  parameter int RW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_leak_tick,
  input  logic             i_syn_valid,
  input  logic             i_syn_inhib,
  input  logic [WIDTH-1:0] i_syn_weight,
  input  logic [WIDTH-1:0] i_thresh,
  input  logic [WIDTH-1:0] i_v_reset,
  input  logic [WIDTH-1:0] i_leak,
  input  logic [RW-1:0]    i_refrac_cycles,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_membrane,
  output logic             o_spike,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [15:0]      o_spike_cnt,
`endif
  output logic             o_refrac
);

  typedef enum logic {S_INTEG, S_REFRAC} state_t;

  state_t           r_state;
  logic [RW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem;
  logic             r_spike;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_v;
  logic             w_fire;

  assign w_sum = {1'b0, r_mem} + {1'b0, i_syn_weight};

  // One guard bit lets the carry and the borrow be caught before clamping.
  always_comb begin
    w_a = {1'b0, r_mem};
    if (i_syn_valid) begin
      if (i_syn_inhib)
        w_a = (r_mem < i_syn_weight) ? '0 : {1'b0, r_mem - i_syn_weight};
      else
        w_a = w_sum[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : w_sum;
    end
    w_v = w_a;
    if (i_leak_tick)
      w_v = (w_a < {1'b0, i_leak}) ? '0 : w_a - {1'b0, i_leak};
  end

  assign w_fire = (w_v >= {1'b0, i_thresh});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INTEG;
      r_cnt   <= '0;
      r_mem   <= '0;
      r_spike <= 1'b0;
    end else if (!i_en) begin
      r_spike <= 1'b0;
    end else if (i_clear) begin
      r_state <= S_INTEG;
      r_cnt   <= '0;
      r_mem   <= i_v_reset;
      r_spike <= 1'b0;
    end else if (r_state == S_REFRAC) begin
      r_spike <= 1'b0;
      r_cnt   <= r_cnt - 1'b1;
      if (r_cnt == RW'(1))
        r_state <= S_INTEG;
    end else if (w_fire) begin
      r_spike <= 1'b1;
      r_mem   <= i_v_reset;
      if (i_refrac_cycles != '0) begin
        r_cnt   <= i_refrac_cycles;
        r_state <= S_REFRAC;
      end
    end else begin
      r_spike <= 1'b0;
      r_mem   <= w_v[WIDTH-1:0];
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] r_spike_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_spike_cnt <= '0;
    else if (i_en) begin
      if (i_clear)
        r_spike_cnt <= '0;
      else if (r_state == S_INTEG && w_fire && r_spike_cnt != 16'hFFFF)
        r_spike_cnt <= r_spike_cnt + 16'd1;
    end
  end

  assign o_spike_cnt = r_spike_cnt;
`endif

  assign o_membrane = r_mem;
  assign o_spike    = r_spike;
  assign o_refrac   = (r_state == S_REFRAC);

endmodule

module lif_neuron_array #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 8,
  parameter int RW       = 4,
  parameter int LEAK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       syn_valid,
  input  logic [NCH-1:0]       syn_inhib,
  input  logic [NCH*WIDTH-1:0] syn_weight,
  input  logic [WIDTH-1:0]     thresh,
  input  logic [WIDTH-1:0]     v_reset,
  input  logic [WIDTH-1:0]     leak,
  input  logic [RW-1:0]        refrac_cycles,
  input  logic [NCH-1:0]       clear,
  output logic [NCH*WIDTH-1:0] membrane,
  output logic [NCH-1:0]       spike,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [NCH*16-1:0]    spike_cnt,
`endif
  output logic [NCH-1:0]       refrac
);

  localparam int DW = (LEAK_DIV > 1) ? $clog2(LEAK_DIV) : 1;

  logic [DW-1:0]                r_div;
  logic                         w_leak_tick;
  logic [NCH-1:0][WIDTH-1:0]    w_weight;
  logic [NCH-1:0][WIDTH-1:0]    w_mem;
`ifdef LIF_SPIKE_COUNT_EN
  logic [NCH-1:0][15:0]         w_cnt;
  assign spike_cnt = w_cnt;
`endif

  assign w_weight    = syn_weight;
  assign membrane    = w_mem;
  assign w_leak_tick = (r_div == DW'(LEAK_DIV - 1));

  // Shared leak divider; frozen with the rest of the state when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_div <= '0;
    else if (en)
      r_div <= w_leak_tick ? '0 : r_div + 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    lif_neuron_lane #(.WIDTH(WIDTH), .RW(RW)) u_lane (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_en            (en),
      .i_leak_tick     (w_leak_tick),
      .i_syn_valid     (syn_valid[g]),
      .i_syn_inhib     (syn_inhib[g]),
      .i_syn_weight    (w_weight[g]),
      .i_thresh        (thresh),
      .i_v_reset       (v_reset),
      .i_leak          (leak),
      .i_refrac_cycles (refrac_cycles),
      .i_clear         (clear[g]),
      .o_membrane      (w_mem[g]),
      .o_spike         (spike[g]),
`ifdef LIF_SPIKE_COUNT_EN
      .o_spike_cnt     (w_cnt[g]),
`endif
      .o_refrac        (refrac[g])
    );
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: expectations queued per cycle, checked 1ns after each rising edge.

module tb_lif_neuron_array;

  localparam int NCH = 4, WIDTH = 8, RW = 4, LEAK_DIV = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NCH-1:0]       syn_valid, syn_inhib, clear;
  logic [NCH*WIDTH-1:0] syn_weight;
  logic [WIDTH-1:0]     thresh, v_reset, leak;
  logic [RW-1:0]        refrac_cycles;
  logic [NCH*WIDTH-1:0] membrane;
  logic [NCH-1:0]       spike, refrac;
`ifdef LIF_SPIKE_COUNT_EN
  logic [NCH*16-1:0]    spike_cnt;
`endif

  lif_neuron_array #(.NCH(NCH), .WIDTH(WIDTH), .RW(RW), .LEAK_DIV(LEAK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .syn_valid(syn_valid), .syn_inhib(syn_inhib),
    .syn_weight(syn_weight), .thresh(thresh), .v_reset(v_reset), .leak(leak),
    .refrac_cycles(refrac_cycles), .clear(clear), .membrane(membrane), .spike(spike),
`ifdef LIF_SPIKE_COUNT_EN
    .spike_cnt(spike_cnt),
`endif
    .refrac(refrac)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    int             ch;
    logic [WIDTH-1:0] mem;
    logic           spk;
    logic           rf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ph    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_ch(input string tag, input int ch, input int mem, input logic spk, input logic rf);
    exp_t e;
    e.tag = tag; e.ch = ch; e.mem = WIDTH'(mem); e.spk = spk; e.rf = rf;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".mem"}, 32'(membrane[e.ch*WIDTH +: WIDTH]), 32'(e.mem));
      chk({e.tag, ".spk"}, 32'(spike[e.ch]), 32'(e.spk));
      chk({e.tag, ".rf"},  32'(refrac[e.ch]), 32'(e.rf));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (en) ph = (ph == LEAK_DIV - 1) ? 0 : ph + 1;
    #1;
    drain();
  endtask

  task automatic idle_inputs();
    syn_valid = '0; syn_inhib = '0; clear = '0; syn_weight = '0;
  endtask

  task automatic set_w(input int ch, input int w, input logic inh);
    syn_valid[ch] = 1'b1;
    syn_inhib[ch] = inh;
    syn_weight[ch*WIDTH +: WIDTH] = WIDTH'(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; idle_inputs();
    thresh = 8'd100; v_reset = 8'd0; leak = 8'd0; refrac_cycles = 4'd3;
    #12;
    for (int c = 0; c < NCH; c++) expect_ch("reset", c, 0, 1'b0, 1'b0);
    drain();
`ifdef LIF_SPIKE_COUNT_EN
    chk("reset.cnt", spike_cnt, '0);
`endif
    rst_n = 1'b1;
    en = 1'b1;

    // Asynchronous reset mid-operation
    @(negedge clk);
    set_w(0, 30, 1'b0);
    expect_ch("pre_rst30", 0, 30, 1'b0, 1'b0); step();
    expect_ch("pre_rst60", 0, 60, 1'b0, 1'b0); step();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) expect_ch("async_rst", c, 0, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b1; ph = 0;

    // Integration, fire, refractory
    thresh = 8'd100; leak = 8'd0; refrac_cycles = 4'd3; v_reset = 8'd0;
    @(negedge clk);
    set_w(0, 30, 1'b0);
    expect_ch("int30", 0, 30, 1'b0, 1'b0); step();
    expect_ch("int60", 0, 60, 1'b0, 1'b0); step();
    expect_ch("int90", 0, 90, 1'b0, 1'b0); step();
    expect_ch("fire",  0, 0,  1'b1, 1'b1); step();
    expect_ch("ref1",  0, 0,  1'b0, 1'b1); step();
    expect_ch("ref2",  0, 0,  1'b0, 1'b1); step();
    expect_ch("ref3",  0, 0,  1'b0, 1'b0); step();
    expect_ch("post_ref", 0, 30, 1'b0, 1'b0); step();
    idle_inputs();

    // Saturation and floor
    thresh = 8'd255; refrac_cycles = 4'd0; v_reset = 8'd250;
    clear[0] = 1'b1;
    expect_ch("ld250", 0, 250, 1'b0, 1'b0); step();
    idle_inputs(); v_reset = 8'd0;
    set_w(0, 20, 1'b0);
    expect_ch("sat_fire", 0, 0, 1'b1, 1'b0); step();
    idle_inputs(); v_reset = 8'd10; clear[1] = 1'b1;
    expect_ch("ld10", 1, 10, 1'b0, 1'b0); step();
    idle_inputs();
    set_w(1, 40, 1'b1);
    expect_ch("floor", 1, 0, 1'b0, 1'b0); step();
    idle_inputs(); thresh = 8'd254; v_reset = 8'd240; clear[2] = 1'b1;
    expect_ch("ld240", 2, 240, 1'b0, 1'b0); step();
    idle_inputs(); thresh = 8'd255; set_w(2, 10, 1'b0);
    expect_ch("no_sat", 2, 250, 1'b0, 1'b0); step();
    idle_inputs();

    // Leak timing from a known divider phase
    do_reset();
    thresh = 8'd255; leak = 8'd5; v_reset = 8'd50; clear[0] = 1'b1;
    expect_ch("ld50", 0, 50, 1'b0, 1'b0); step();
    idle_inputs();
    begin
      int m;
      m = 50;
      for (int k = 0; k < 12; k++) begin
        if (ph == LEAK_DIV - 1) m = (m > 5) ? m - 5 : 0;
        expect_ch($sformatf("leak%0d", k), 0, m, 1'b0, 1'b0); step();
      end
      v_reset = 8'd7; clear[0] = 1'b1; m = 7;
      if (ph == LEAK_DIV - 1) m = 7;
      expect_ch("ld7", 0, m, 1'b0, 1'b0); step();
      idle_inputs();
      for (int k = 0; k < 12; k++) begin
        if (ph == LEAK_DIV - 1) m = (m > 5) ? m - 5 : 0;
        expect_ch($sformatf("lfloor%0d", k), 0, m, 1'b0, 1'b0); step();
      end
      chk("leak_end", 32'(membrane[0 +: WIDTH]), 32'd0);
    end

    // Clear beats firing input; neighbour fires normally
    do_reset();
    leak = 8'd0; thresh = 8'd100; refrac_cycles = 4'd0; v_reset = 8'd5;
    clear[1] = 1'b1; set_w(1, 200, 1'b0); set_w(2, 200, 1'b0);
    expect_ch("clr_wins", 1, 5, 1'b0, 1'b0);
    expect_ch("nbr_fire", 2, 5, 1'b1, 1'b0); step();
    idle_inputs();

    // Enable low freezes membranes and refractory countdown
    v_reset = 8'd0; refrac_cycles = 4'd2;
    set_w(0, 40, 1'b0); set_w(3, 150, 1'b0);
    expect_ch("pre_frz0", 0, 40, 1'b0, 1'b0);
    expect_ch("pre_frz3", 3, 0, 1'b1, 1'b1); step();
    en = 1'b0; set_w(0, 30, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_ch($sformatf("frz0_%0d", k), 0, 40, 1'b0, 1'b0);
      expect_ch($sformatf("frz3_%0d", k), 3, 0, 1'b0, 1'b1); step();
    end
    idle_inputs(); en = 1'b1;
    expect_ch("thaw_r1", 3, 0, 1'b0, 1'b1); step();
    expect_ch("thaw_r0", 3, 0, 1'b0, 1'b0);
    expect_ch("thaw_m",  0, 40, 1'b0, 1'b0); step();

`ifdef LIF_SPIKE_COUNT_EN
    do_reset();
    thresh = 8'd0; refrac_cycles = 4'd0; v_reset = 8'd0; leak = 8'd0;
    clear[0] = 1'b1;
    expect_ch("cnt_clr", 0, 0, 1'b0, 1'b0); step();
    chk("cnt0", 32'(spike_cnt[15:0]), 32'd0);
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      expect_ch($sformatf("cnt_fire%0d", k), 0, 0, 1'b1, 1'b0); step();
      chk($sformatf("cnt%0d", k), 32'(spike_cnt[15:0]), 32'(k));
    end
    clear[0] = 1'b1;
    expect_ch("cnt_clr2", 0, 0, 1'b0, 1'b0); step();
    chk("cnt_zero", 32'(spike_cnt[15:0]), 32'd0);
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
